d_mem_lsu: RTL and testbench

// Load/store unit directly downstream of the gpc_4t core's Q102H data-memory port; produces the Q103H read data the core writes back.

---
 rtl/d_mem_lsu_if.sv | 56 +++++
 rtl/d_mem_lsu.sv | 145 ++++++++++++++
 tb/tb_d_mem_lsu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/d_mem_lsu_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : d_mem_lsu_if                                                  |
// | Brief  : Core, SRAM and fabric bus bundle around the load/store unit   |
// | Rev    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------+
interface d_mem_lsu_if #(
   parameter int LOCAL_AW     = 14,
   parameter int ST_BUF_DEPTH = 4
);
   localparam int CW = $clog2(ST_BUF_DEPTH) + 1;

   // core Q102H request / Q103H response
   logic [31:0]         MemAdrsQ102H;
   logic [31:0]         MemWrDataWQ102H;
   logic                CtrlMemWrQ102H;
   logic                CtrlMemRdQ102H;
   logic [3:0]          MemByteEnQ102H;
   logic                MemSignExtQ102H;
   logic [31:0]         MemRdDataQ103H;
   // tile SRAM
   logic [LOCAL_AW-3:0] SramAdrsQ102H;
   logic                SramWrEnQ102H;
   logic                SramRdEnQ102H;
   logic [3:0]          SramByteEnQ102H;
   logic [31:0]         SramWrDataQ102H;
   logic [31:0]         SramRdDataQ103H;
   // fabric store port
   logic                FabReqValid;
   logic                FabReqReady;
   logic [31:0]         FabReqAdrs;
   logic [31:0]         FabReqData;
   logic [3:0]          FabReqByteEn;
   // status
   logic [CW-1:0]       StBufCount;
   logic [2:0]          ErrStickyQnnnH;

   // LSU side
   modport slave (
      input  MemAdrsQ102H, MemWrDataWQ102H, CtrlMemWrQ102H, CtrlMemRdQ102H,
             MemByteEnQ102H, MemSignExtQ102H, SramRdDataQ103H, FabReqReady,
      output MemRdDataQ103H, SramAdrsQ102H, SramWrEnQ102H, SramRdEnQ102H,
             SramByteEnQ102H, SramWrDataQ102H, FabReqValid, FabReqAdrs,
             FabReqData, FabReqByteEn, StBufCount, ErrStickyQnnnH
   );

   // core / SRAM / fabric side
   modport master (
      output MemAdrsQ102H, MemWrDataWQ102H, CtrlMemWrQ102H, CtrlMemRdQ102H,
             MemByteEnQ102H, MemSignExtQ102H, SramRdDataQ103H, FabReqReady,
      input  MemRdDataQ103H, SramAdrsQ102H, SramWrEnQ102H, SramRdEnQ102H,
             SramByteEnQ102H, SramWrDataQ102H, FabReqValid, FabReqAdrs,
             FabReqData, FabReqByteEn, StBufCount, ErrStickyQnnnH
   );
endinterface
`default_nettype wire

// File: rtl/d_mem_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : d_mem_lsu                                                     |
// | Brief  : Load/store unit: lane alignment, local SRAM access, posted    |
// |          fabric store buffer, Q103H load extract/extend               |
// | Rev    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------+
module d_mem_lsu #(
   parameter logic [31:0] LOCAL_BASE   = 32'h0000_0000,
   parameter int          LOCAL_AW     = 14,
   parameter int          ST_BUF_DEPTH = 4
) (
   input  wire logic      QClk,
   input  wire logic      RstQnnnH,
   d_mem_lsu_if.slave     bus
);
   localparam int PW = $clog2(ST_BUF_DEPTH);
   localparam int CW = PW + 1;

   // Q102H decode
   logic [1:0]  w_off;
   logic        w_sz_b, w_sz_h, w_sz_w;
   logic        w_mis, w_local, w_store, w_load;
   logic        w_push, w_pop, w_push_ok, w_drop, w_nl_load;
   logic [3:0]  w_lane_be;
   logic [31:0] w_lane_data;

   // Q103H pipe
   logic [1:0]  r_off;
   logic [3:0]  r_be;
   logic        r_sext, r_lrd, r_erd;
   logic [31:0] w_shift;
   logic [31:0] w_rd_data;

   // store buffer
   logic [31:0] r_fa [ST_BUF_DEPTH];
   logic [31:0] r_fd [ST_BUF_DEPTH];
   logic [3:0]  r_fb [ST_BUF_DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_count;
   logic [2:0]    r_err;

   // Request classification, lane alignment and routing for the current access.
   // A cycle with both Rd and Wr set is handled purely as a store.
   always_comb begin
      w_off       = bus.MemAdrsQ102H[1:0];
      w_sz_b      = (bus.MemByteEnQ102H == 4'b0001);
      w_sz_h      = (bus.MemByteEnQ102H == 4'b0011);
      w_sz_w      = !w_sz_b && !w_sz_h;
      w_mis       = (bus.CtrlMemRdQ102H || bus.CtrlMemWrQ102H) &&
                    ((w_sz_h && w_off[0]) || (w_sz_w && (w_off != 2'b00)));
      w_local     = (bus.MemAdrsQ102H[31:LOCAL_AW] == LOCAL_BASE[31:LOCAL_AW]);
      w_store     = bus.CtrlMemWrQ102H && !w_mis;
      w_load      = bus.CtrlMemRdQ102H && !bus.CtrlMemWrQ102H && !w_mis;
      w_lane_be   = bus.MemByteEnQ102H << w_off;
      w_lane_data = w_sz_b ? {4{bus.MemWrDataWQ102H[7:0]}}  :
                    w_sz_h ? {2{bus.MemWrDataWQ102H[15:0]}} :
                             bus.MemWrDataWQ102H;
      w_push      = w_store && !w_local;
      w_nl_load   = w_load && !w_local;
      w_pop       = (r_count != '0) && bus.FabReqReady;
      // A full buffer still takes a store if its head drains this cycle.
      w_push_ok   = w_push && ((r_count < CW'(ST_BUF_DEPTH)) || w_pop);
      w_drop      = w_push && !w_push_ok;
   end

   assign bus.SramAdrsQ102H   = bus.MemAdrsQ102H[LOCAL_AW-1:2];
   assign bus.SramWrEnQ102H   = w_store && w_local;
   assign bus.SramRdEnQ102H   = w_load && w_local;
   assign bus.SramByteEnQ102H = w_lane_be;
   assign bus.SramWrDataQ102H = w_lane_data;

   // Carry the load's lane/size/extend info alongside the SRAM read into Q103H.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         r_off  <= '0;
         r_be   <= '0;
         r_sext <= 1'b0;
         r_lrd  <= 1'b0;
         r_erd  <= 1'b0;
      end else begin
         r_off  <= w_off;
         r_be   <= bus.MemByteEnQ102H;
         r_sext <= bus.MemSignExtQ102H;
         r_lrd  <= w_load && w_local;
         r_erd  <= bus.CtrlMemRdQ102H && !bus.CtrlMemWrQ102H && (w_mis || !w_local);
      end
   end

   // Pick the addressed byte/half from the SRAM word and extend it; zero otherwise.
   always_comb begin
      w_shift   = bus.SramRdDataQ103H >> {r_off, 3'b000};
      w_rd_data = '0;
      if (r_lrd && !r_erd) begin
         if (r_be == 4'b0001)
            w_rd_data = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
         else if (r_be == 4'b0011)
            w_rd_data = {{16{r_sext & w_shift[15]}}, w_shift[15:0]};
         else
            w_rd_data = bus.SramRdDataQ103H;
      end
   end

   assign bus.MemRdDataQ103H = w_rd_data;

   // Store-buffer payload; contents are dead unless covered by the pointers.
   always_ff @(posedge QClk) begin
      if (w_push_ok) begin
         r_fa[r_wp] <= {bus.MemAdrsQ102H[31:2], 2'b00};
         r_fd[r_wp] <= w_lane_data;
         r_fb[r_wp] <= w_lane_be;
      end
   end

   // Store-buffer pointers and occupancy; reset discards anything buffered.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wp <= r_wp + PW'(1);
         if (w_pop)     r_rp <= r_rp + PW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flags {drop_on_full, nonlocal_load, misaligned}.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) r_err <= '0;
      else          r_err <= r_err | {w_drop, w_nl_load, w_mis};
   end

   assign bus.FabReqValid    = (r_count != '0);
   assign bus.FabReqAdrs     = bus.FabReqValid ? r_fa[r_rp] : '0;
   assign bus.FabReqData     = bus.FabReqValid ? r_fd[r_rp] : '0;
   assign bus.FabReqByteEn   = bus.FabReqValid ? r_fb[r_rp] : '0;
   assign bus.StBufCount     = r_count;
   assign bus.ErrStickyQnnnH = r_err;
endmodule
`default_nettype wire

// File: tb/tb_d_mem_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_d_mem_lsu                                                  |
// | Brief  : Directed + random bench for d_mem_lsu with reference model    |
// | Rev    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------+
module tb_d_mem_lsu;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
   } fab_t;

   // reference state: byte memory of the local window, fabric queue, flags
   logic [7:0]  ref_mem [0:16383];
   fab_t        fq [$];
   logic [2:0]  exp_err;

   // SRAM behaviour seen by the DUT
   logic [31:0] sram_mem [0:4095];

   d_mem_lsu_if #(.LOCAL_AW(14), .ST_BUF_DEPTH(DEPTH)) bus ();

   d_mem_lsu #(.LOCAL_BASE(32'h0), .LOCAL_AW(14), .ST_BUF_DEPTH(DEPTH)) dut (
      .QClk     (clk),
      .RstQnnnH (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Single-port SRAM with one cycle read latency; cleared while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) sram_mem[i] <= '0;
         bus.SramRdDataQ103H <= '0;
      end else begin
         if (bus.SramWrEnQ102H)
            for (int i = 0; i < 4; i++)
               if (bus.SramByteEnQ102H[i])
                  sram_mem[bus.SramAdrsQ102H][8*i +: 8] <= bus.SramWrDataQ102H[8*i +: 8];
         if (bus.SramRdEnQ102H)
            bus.SramRdDataQ103H <= sram_mem[bus.SramAdrsQ102H];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] repl(input logic [31:0] d, input int sz);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   // One Q102H cycle: entered just after a negedge, returns at the next negedge
   // after checking the Q103H result and the flags for this request.
   task automatic do_cycle(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input bit sx, input bit rdy);
      int          sz;
      bit          mis, loc, st, ld, pop;
      logic [31:0] exp_rd;
      logic [3:0]  lbe;
      fab_t        e;
      bus.MemAdrsQ102H    = a;
      bus.MemWrDataWQ102H = d;
      bus.CtrlMemRdQ102H  = rd;
      bus.CtrlMemWrQ102H  = wr;
      bus.MemByteEnQ102H  = be;
      bus.MemSignExtQ102H = sx;
      bus.FabReqReady     = rdy;
      #1;
      sz  = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : 4;
      mis = (rd || wr) && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
      loc = (a[31:14] == 18'd0);
      st  = wr && !mis;
      ld  = rd && !wr && !mis;
      lbe = '0;
      for (int i = 0; i < sz; i++) lbe[a[1:0] + i] = 1'b1;
      check_eq("sram_wr_en", 32'(bus.SramWrEnQ102H), 32'(st && loc));
      check_eq("sram_rd_en", 32'(bus.SramRdEnQ102H), 32'(ld && loc));
      if ((st || ld) && loc) begin
         check_eq("sram_adrs", 32'(bus.SramAdrsQ102H), 32'(a[13:2]));
         check_eq("sram_be", 32'(bus.SramByteEnQ102H), 32'(lbe));
      end
      if (st && loc) check_eq("sram_wdata", bus.SramWrDataQ102H, repl(d, sz));
      check_eq("fab_valid", 32'(bus.FabReqValid), 32'(fq.size() != 0));
      check_eq("st_count", 32'(bus.StBufCount), 32'(fq.size()));
      if (fq.size() != 0) begin
         check_eq("fab_adrs", bus.FabReqAdrs, fq[0].a);
         check_eq("fab_data", bus.FabReqData, fq[0].d);
         check_eq("fab_be", 32'(bus.FabReqByteEn), 32'(fq[0].b));
      end
      pop = (fq.size() != 0) && rdy;
      exp_rd = '0;
      if (ld && loc) begin
         for (int i = 0; i < sz; i++) exp_rd[8*i +: 8] = ref_mem[a[13:0] + 14'(i)];
         if (sx && sz < 4 && exp_rd[8*sz-1])
            for (int i = 8*sz; i < 32; i++) exp_rd[i] = 1'b1;
      end
      @(posedge clk);
      if (pop) void'(fq.pop_front());
      if (st && !loc) begin
         if (fq.size() < DEPTH) begin
            e.a = {a[31:2], 2'b00};
            e.d = repl(d, sz);
            e.b = lbe;
            fq.push_back(e);
         end else begin
            exp_err[2] = 1'b1;
         end
      end
      if (st && loc)
         for (int i = 0; i < sz; i++) ref_mem[a[13:0] + 14'(i)] = d[8*i +: 8];
      if (ld && !loc) exp_err[1] = 1'b1;
      if (mis)        exp_err[0] = 1'b1;
      @(negedge clk);
      check_eq("rd_data", bus.MemRdDataQ103H, exp_rd);
      check_eq("err_sticky", 32'(bus.ErrStickyQnnnH), 32'(exp_err));
   endtask

   task automatic idle();
      bus.CtrlMemRdQ102H = 1'b0;
      bus.CtrlMemWrQ102H = 1'b0;
   endtask

   initial begin
      bit          rd, wr, sx, rdy;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          k;
      for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
      exp_err = '0;
      idle();
      bus.MemAdrsQ102H    = '0;
      bus.MemWrDataWQ102H = '0;
      bus.MemByteEnQ102H  = '0;
      bus.MemSignExtQ102H = 1'b0;
      bus.FabReqReady     = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_rd_data", bus.MemRdDataQ103H, 32'h0);
      check_eq("rst_valid", 32'(bus.FabReqValid), 32'h0);
      check_eq("rst_count", 32'(bus.StBufCount), 32'h0);
      check_eq("rst_err", 32'(bus.ErrStickyQnnnH), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // local word store / load
      do_cycle(0, 1, 32'h10, 32'h1122_3344, 4'hF, 0, 0);
      do_cycle(1, 0, 32'h10, 32'h0, 4'hF, 0, 0);
      check_eq("lw_value", bus.MemRdDataQ103H, 32'h1122_3344);
      // byte store, signed and unsigned byte loads
      do_cycle(0, 1, 32'h13, 32'h0000_00F0, 4'h1, 0, 0);
      do_cycle(1, 0, 32'h13, 32'h0, 4'h1, 1, 0);
      check_eq("lb_value", bus.MemRdDataQ103H, 32'hFFFF_FFF0);
      do_cycle(1, 0, 32'h13, 32'h0, 4'h1, 0, 0);
      check_eq("lbu_value", bus.MemRdDataQ103H, 32'h0000_00F0);
      // misaligned half store, then signed upper-half load
      do_cycle(0, 1, 32'h11, 32'hBEEF, 4'h3, 0, 0);
      check_eq("mis_err", 32'(bus.ErrStickyQnnnH), 32'h1);
      do_cycle(0, 1, 32'h10, 32'h8001_5555, 4'hF, 0, 0);
      do_cycle(1, 0, 32'h12, 32'h0, 4'h3, 1, 0);
      check_eq("lh_value", bus.MemRdDataQ103H, 32'hFFFF_8001);

      // five non-local stores into a stalled fabric: the fifth is dropped
      for (int i = 0; i < 5; i++)
         do_cycle(0, 1, 32'h8000_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 0, 0);
      check_eq("full_count", 32'(bus.StBufCount), 32'd4);
      // full buffer, store and pop in the same cycle
      do_cycle(0, 1, 32'h8000_0100, 32'hCAFE_F00D, 4'hF, 0, 1);
      check_eq("full_pop_push", 32'(bus.StBufCount), 32'd4);
      // non-local load while draining, then asynchronous reset mid-drain
      do_cycle(1, 0, 32'h8000_0200, 32'h0, 4'hF, 0, 1);
      idle();
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_valid", 32'(bus.FabReqValid), 32'h0);
      check_eq("async_rst_count", 32'(bus.StBufCount), 32'h0);
      check_eq("async_rst_err", 32'(bus.ErrStickyQnnnH), 32'h0);
      fq.delete();
      exp_err = '0;
      for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         k   = int'($urandom_range(0, 5));
         rd  = (k == 1 || k == 2 || k == 5);
         wr  = (k == 3 || k == 4 || k == 5);
         k   = int'($urandom_range(0, 2));
         be  = (k == 0) ? 4'h1 : (k == 1) ? 4'h3 : 4'hF;
         if ($urandom_range(0, 9) < 7) a = 32'h100 + 32'($urandom_range(0, 31));
         else                          a = 32'h8000_0000 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) != 0) begin
            if (be == 4'h3) a[0] = 1'b0;
            if (be == 4'hF) a[1:0] = 2'b00;
         end
         d   = $urandom;
         sx  = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 3) == 0);
         do_cycle(rd, wr, a, d, be, sx, rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
